// File: rtl/reminder_interval_timer.sv
// ============================================================================
// reminder_interval_timer
//
// Water-drink reminder built on top of the clock divider. Each rising edge of
// slow_clk (detected in the clk domain) is one "reminder second". The block
// counts down a user-selected interval, raises an alert when it expires, and
// lets the user acknowledge (restart the interval) or snooze (postpone the
// alert by a fixed number of minutes). Alerts left unacknowledged for
// ALERT_TIMEOUT_SEC seconds bump a saturating missed-reminder counter.
//
// Parameters
//   SNOOZE_MIN         snooze length in minutes (1..255)
//   ALERT_TIMEOUT_SEC  seconds an alert may stay unacked before it counts as
//                      missed (1..65535)
//
// Ports
//   clk            in   1   system clock, shared with the divider
//   reset          in   1   asynchronous, active-high; clears all state
//   slow_clk       in   1   divider output, synchronous to clk
//   enable         in   1   1 = reminder running, 0 = forced to IDLE
//   interval_min   in   8   drink interval in minutes (0 behaves as 1)
//   ack            in   1   level: user drank, restart the interval
//   snooze         in   1   level: postpone a pending alert
//   state          out  2   0=IDLE 1=COUNT 2=ALERT 3=SNOOZE
//   remaining_sec  out  16  seconds left in the current COUNT/SNOOZE period
//   alert          out  1   high while in ALERT
//   blink          out  1   toggles on every tick while in ALERT, else 0
//   missed_count   out  4   timed-out alerts since the last ack, saturating
//
// Event priority on every clk edge: enable=0 > ack > snooze > tick.
// ============================================================================
module reminder_interval_timer #(
    parameter int unsigned SNOOZE_MIN        = 5,
    parameter int unsigned ALERT_TIMEOUT_SEC = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        slow_clk,
    input  logic        enable,
    input  logic [7:0]  interval_min,
    input  logic        ack,
    input  logic        snooze,
    output logic [1:0]  state,
    output logic [15:0] remaining_sec,
    output logic        alert,
    output logic        blink,
    output logic [3:0]  missed_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_ALERT  = 2'd2,
        ST_SNOOZE = 2'd3
    } state_t;

    // Snooze reload value and alert timeout, both in seconds.
    localparam logic [15:0] SNOOZE_LOAD   = 16'(SNOOZE_MIN * 60);
    localparam logic [15:0] ALERT_TIMEOUT = 16'(ALERT_TIMEOUT_SEC);

    state_t      state_q;
    state_t      state_d;
    logic        slow_q;
    logic        tick;
    logic [7:0]  interval_eff;
    logic [15:0] interval_load;
    logic        period_expiring;
    logic        alert_timed_out;
    logic [15:0] alert_sec_q;
    logic [15:0] alert_sec_d;
    logic [15:0] remaining_d;
    logic        alert_d;
    logic        blink_d;
    logic [3:0]  missed_d;

    // ------------------------------------------------------------------
    // Tick detection: one tick per slow_clk rising edge, no matter how long
    // slow_clk stays high.
    // ------------------------------------------------------------------
    assign tick = slow_clk & ~slow_q;

    // Interval reload value. interval_min is only looked at when a load
    // happens, so changing it mid-count has no effect until the next load.
    // 255 * 60 = 15300 fits comfortably in 16 bits.
    assign interval_eff  = (interval_min == 8'd0) ? 8'd1 : interval_min;
    assign interval_load = 16'(interval_eff) * 16'd60;

    // Last second of a COUNT/SNOOZE period is being consumed this edge.
    assign period_expiring = tick && (remaining_sec == 16'd1);

    // This tick completes another full timeout window in ALERT.
    assign alert_timed_out = tick && ((alert_sec_q + 16'd1) == ALERT_TIMEOUT);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    // NOTE: every register here is written with <= so all of them sample the
    // values computed before this edge; blocking writes would let later
    // statements see half-updated state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            slow_q        <= 1'b0;
            remaining_sec <= 16'd0;
            alert         <= 1'b0;
            blink         <= 1'b0;
            missed_count  <= 4'd0;
            alert_sec_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            slow_q        <= slow_clk;
            remaining_sec <= remaining_d;
            alert         <= alert_d;
            blink         <= blink_d;
            missed_count  <= missed_d;
            alert_sec_q   <= alert_sec_d;
        end
    end

    assign state = state_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment at the top of each always_comb covers
    // every path, so no latch can be inferred for an unassigned branch.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_COUNT;
                end
                ST_COUNT: begin
                    // ack only reloads; expiry needs a tick without ack.
                    if (!ack && period_expiring) begin
                        state_d = ST_ALERT;
                    end
                end
                ST_ALERT: begin
                    if (ack) begin
                        state_d = ST_COUNT;
                    end else if (snooze) begin
                        state_d = ST_SNOOZE;
                    end
                end
                ST_SNOOZE: begin
                    // snooze has no effect here; only ack or expiry leave.
                    if (ack) begin
                        state_d = ST_COUNT;
                    end else if (period_expiring) begin
                        state_d = ST_ALERT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath logic: next values of the registered outputs and of
    // the alert-second counter.
    // ------------------------------------------------------------------
    always_comb begin
        remaining_d = remaining_sec;
        alert_d     = alert;
        blink_d     = blink;
        missed_d    = missed_count;
        alert_sec_d = alert_sec_q;

        if (!enable) begin
            // Disabled: park everything except the missed counter, which
            // keeps its history until the user acknowledges.
            remaining_d = 16'd0;
            alert_d     = 1'b0;
            blink_d     = 1'b0;
            alert_sec_d = 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    remaining_d = interval_load;
                    alert_d     = 1'b0;
                    blink_d     = 1'b0;
                    alert_sec_d = 16'd0;
                    if (ack) begin
                        missed_d = 4'd0;
                    end
                end

                ST_COUNT, ST_SNOOZE: begin
                    if (ack) begin
                        // Early drink restarts the full interval.
                        remaining_d = interval_load;
                        missed_d    = 4'd0;
                    end else if (tick) begin
                        if (remaining_sec == 16'd1) begin
                            remaining_d = 16'd0;
                            alert_d     = 1'b1;
                            blink_d     = 1'b0;
                            alert_sec_d = 16'd0;
                        end else if (remaining_sec != 16'd0) begin
                            // Guarded so the counter can never wrap.
                            remaining_d = remaining_sec - 16'd1;
                        end
                    end
                end

                ST_ALERT: begin
                    if (ack) begin
                        remaining_d = interval_load;
                        alert_d     = 1'b0;
                        blink_d     = 1'b0;
                        missed_d    = 4'd0;
                        alert_sec_d = 16'd0;
                    end else if (snooze) begin
                        // Postpone; the missed history is kept.
                        remaining_d = SNOOZE_LOAD;
                        alert_d     = 1'b0;
                        blink_d     = 1'b0;
                        alert_sec_d = 16'd0;
                    end else if (tick) begin
                        blink_d = ~blink;
                        if (alert_timed_out) begin
                            // Stay in ALERT and start a new timeout window.
                            alert_sec_d = 16'd0;
                            missed_d    = (missed_count == 4'hF) ? 4'hF
                                                                 : missed_count + 4'd1;
                        end else begin
                            alert_sec_d = alert_sec_q + 16'd1;
                        end
                    end
                end

                default: begin
                    remaining_d = 16'd0;
                    alert_d     = 1'b0;
                    blink_d     = 1'b0;
                    alert_sec_d = 16'd0;
                end
            endcase
        end
    end

endmodule
